// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and divider helper for the UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned CLK_FREQ_DEFAULT  = 100_000_000;
  localparam int unsigned BAUD_RATE_DEFAULT = 115_200;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  // Clock cycles per oversampling tick, integer-truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// 16x-oversampling tick generator; the counter is held at zero while disabled.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEFAULT
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_baud_tick
);

  localparam int unsigned Div  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  if (Div < 1) begin : g_div_check
    $error("baud_rate_gen: CLK_FREQ too low for BAUD_RATE * 16");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            term;

  assign term        = (cnt_q == CntW'(Div - 1));
  assign o_baud_tick = i_en && term;

  always_comb begin
    cnt_d = '0;
    if (i_en) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// 8N1 UART receiver: input synchronizer, oversampling FSM and output register.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEFAULT
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_valid
);

  localparam int unsigned SCntW = $clog2(OVERSAMPLE);
  localparam int unsigned BCntW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  rx_state_e          state_q, state_d;
  logic [SCntW-1:0]   s_cnt_q, s_cnt_d;
  logic [BCntW-1:0]   b_cnt_q, b_cnt_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall, baud_tick, mid_start, bit_end, last_bit;

  baud_rate_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_rate_gen (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_en        (state_q != StIdle),
    .o_baud_tick (baud_tick)
  );

  // Idle-high reset values keep a released reset from looking like a start edge.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall   = rx_prev_q && !rx_sync_q;
  assign mid_start = baud_tick && (s_cnt_q == SCntW'(OVERSAMPLE / 2 - 1));
  assign bit_end   = baud_tick && (s_cnt_q == SCntW'(OVERSAMPLE - 1));
  assign last_bit  = (b_cnt_q == BCntW'(NB_DATA - 1));

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rx_fall)             state_d = StStart;
      StStart: if (mid_start)           state_d = rx_sync_q ? StIdle : StData;
      StData:  if (bit_end && last_bit) state_d = StStop;
      StStop:  if (bit_end)             state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cnt_d = s_cnt_q;
    b_cnt_d = b_cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = done_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          s_cnt_d = '0;
          b_cnt_d = '0;
          done_d  = 1'b0;
        end
      end
      StStart: begin
        if (baud_tick) s_cnt_d = mid_start ? '0 : s_cnt_q + 1'b1;
      end
      StData: begin
        if (baud_tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
          if (bit_end) begin
            shift_d = {rx_sync_q, shift_q[NB_DATA-1:1]};
            b_cnt_d = last_bit ? '0 : b_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (baud_tick) begin
          s_cnt_d = s_cnt_q + 1'b1;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (bit_end && rx_sync_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      s_cnt_q <= '0;
      b_cnt_q <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_cnt_q <= s_cnt_d;
      b_cnt_q <= b_cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign o_rx_data = data_q;
  assign o_rx_done = done_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: serial frames in, byte-level model out.
module tb_uart_rx_top;

  logic       clk;
  logic       i_rst;
  logic       i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_valid;

  uart_rx_top dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_rx      (i_rx),
    .o_rx_data (o_rx_data),
    .o_rx_done (o_rx_done),
    .o_valid   (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Byte-level reference model.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_done = 1'b0;

  int   valid_run  = 0;
  int   valid_wide = 0;
  bit   done_fell  = 1'b0;
  logic done_prev  = 1'b0;
  int   tick_cnt   = 0;
  int   tick_gap   = 0;
  int   gap_bad    = 0;
  bit   gap_valid  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back(o_rx_data);
      valid_run++;
      if (valid_run > 1) valid_wide++;
    end else begin
      valid_run = 0;
    end
    if (done_prev && !o_rx_done) done_fell = 1'b1;
    done_prev = o_rx_done;
    tick_gap++;
    if (dut.baud_tick) begin
      tick_cnt++;
      // Gaps >= 100 span an idle period between frames.
      if (gap_valid && tick_gap < 100 && tick_gap != 54) gap_bad++;
      tick_gap  = 0;
      gap_valid = 1'b1;
    end
  end

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int bp);
    i_rx = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (bp) @(negedge clk);
    end
    i_rx = stop_bit;
    repeat (bp) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bp);
    exp_done = 1'b0;
    drive_frame(b, stop_bit, bp);
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_data = b;
      exp_done = 1'b1;
    end
  endtask

  task automatic compare_rx(input string tag);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_data"}, o_rx_data, exp_data);
    check({tag, "_done"}, o_rx_done, exp_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int bp;
    int tc;
    logic [7:0] rb;

    i_rst = 1'b0;
    i_rx  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("rst_data", o_rx_data, 8'h00);
    check("rst_done", o_rx_done, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    @(negedge clk);
    i_rst = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal frame from a slightly slow (8.68 us) transmitter.
    tick_cnt = 0;
    send_frame(8'h55, 1'b1, 868);
    compare_rx("f55");
    check("ticks_per_frame", tick_cnt, 152);
    repeat (2000) @(negedge clk);
    #1;
    check("idle_no_ticks", tick_cnt, 152);
    check("done_hold", o_rx_done, 1'b1);

    // Back-to-back frames with no idle gap.
    done_fell = 1'b0;
    bp = $urandom_range(850, 880);
    send_frame(8'hA3, 1'b1, bp);
    send_frame(8'h0F, 1'b1, bp);
    compare_rx("b2b");
    check("b2b_done_fell", done_fell, 1'b1);

    // Framing error followed by a break that must not retrigger.
    bp = $urandom_range(850, 880);
    send_frame(8'h3C, 1'b0, bp);
    i_rx = 1'b0;
    repeat (2 * bp) @(negedge clk);
    i_rx = 1'b1;
    repeat (300) @(negedge clk);
    compare_rx("ferr");

    // 2 us low glitch: one false start, eight ticks, then back to idle.
    tc = tick_cnt;
    i_rx = 1'b0;
    repeat (200) @(negedge clk);
    i_rx = 1'b1;
    repeat (1000) @(negedge clk);
    compare_rx("glitch");
    check("glitch_ticks", tick_cnt - tc, 8);
    tc = tick_cnt;
    repeat (500) @(negedge clk);
    #1;
    check("glitch_idle", tick_cnt - tc, 0);

    bp = $urandom_range(850, 880);
    send_frame(8'h81, 1'b1, bp);
    compare_rx("f81");

    // Reset in the middle of data bit 4 (a high bit, so no edge after release).
    fork
      drive_frame(8'hF0, 1'b1, 868);
    join_none
    repeat (868 * 5 + 434) @(negedge clk);
    i_rst = 1'b0;
    #1;
    check("midrst_data", o_rx_data, 8'h00);
    check("midrst_done", o_rx_done, 1'b0);
    check("midrst_valid", o_valid, 1'b0);
    exp_data = 8'h00;
    exp_done = 1'b0;
    repeat (10) @(negedge clk);
    i_rst = 1'b1;
    wait fork;
    repeat (200) @(negedge clk);
    compare_rx("midrst_tail");

    bp = $urandom_range(850, 880);
    send_frame(8'h7E, 1'b1, bp);
    compare_rx("f7e");

    // Random byte, rate and inter-frame gap.
    rb = 8'($urandom);
    bp = $urandom_range(848, 880);
    repeat ($urandom_range(1, 40)) @(negedge clk);
    send_frame(rb, 1'b1, bp);
    compare_rx("rand");

    check("tick_spacing_bad", gap_bad, 0);
    check("valid_width_bad", valid_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
